// File: rtl/bcd_field_reg_if.sv
// -----------------------------------------------------------------------------
// bcd_field_reg_if
// Purpose : Bundles the controller-side signals of one packed-BCD RTC field
//           register (edit keys, reload path, write-back tracking).
// Ports   : parameter W = data width in bits (4 * number of BCD digits)
//   UP, DOWN     level step requests (already synchronised)
//   Modificando  1 = user edit mode
//   Actualizar   load DATA_in (honoured only when Modificando = 0)
//   DATA_in      BCD value from the RTC read path
//   Clear_mod    clears Modificado after write-back
//   Max_in       dynamic upper bound (only when DYN_MAX_EN is defined)
//   DATA_out     current BCD value
//   Cambio       1-cycle pulse per manual step
//   Modificado   sticky "edited" flag
//   Load_err     1-cycle pulse when a load is rejected
// Handshake: none. All inputs are plain levels sampled every clock and all
//           outputs are registered levels or single-cycle pulses.
// Modports: master = controller side, slave = field register side.
// -----------------------------------------------------------------------------
interface bcd_field_reg_if #(
   parameter int W = 8
);
   logic         UP;
   logic         DOWN;
   logic         Modificando;
   logic         Actualizar;
   logic [W-1:0] DATA_in;
   logic         Clear_mod;
`ifdef DYN_MAX_EN
   logic [W-1:0] Max_in;
`endif
   logic [W-1:0] DATA_out;
   logic         Cambio;
   logic         Modificado;
   logic         Load_err;

   modport master (
      output UP, DOWN, Modificando, Actualizar, DATA_in, Clear_mod,
`ifdef DYN_MAX_EN
      output Max_in,
`endif
      input  DATA_out, Cambio, Modificado, Load_err
   );

   modport slave (
      input  UP, DOWN, Modificando, Actualizar, DATA_in, Clear_mod,
`ifdef DYN_MAX_EN
      input  Max_in,
`endif
      output DATA_out, Cambio, Modificado, Load_err
   );
endinterface

// File: rtl/bcd_field_reg.sv
// -----------------------------------------------------------------------------
// bcd_field_reg
// Purpose : Packed-BCD register for one RTC time/date field. In edit mode the
//           value steps with UP/DOWN (first step immediately, then hold-off,
//           then auto-repeat); outside edit mode it reloads from the RTC read
//           path. Tracks whether the user edited the field.
// Ports   :
//   CLK        system clock
//   RST        synchronous, active-high reset
//   bus        bcd_field_reg_if.slave (see interface for signal list)
//   dbg_state  current key FSM state (0 = IDLE, 1 = HOLD, 2 = REPEAT)
// Optional feature macro: DYN_MAX_EN
//   defined   -> bus.Max_in replaces MAX_VAL as upper bound for wrap and load
//                checks, and a value above Max_in is clamped down to it.
//   undefined -> MAX_VAL is the fixed upper bound, no clamp logic.
// Priority  : RST > load > clamp (DYN_MAX_EN only) > step.
// -----------------------------------------------------------------------------
module bcd_field_reg #(
   parameter int                  DIGITS        = 2,
   parameter logic [4*DIGITS-1:0] MIN_VAL       = '0,
   parameter logic [4*DIGITS-1:0] MAX_VAL       = (4*DIGITS)'(8'h59),
   parameter logic [4*DIGITS-1:0] RESET_VAL     = MIN_VAL,
   parameter int                  HOLD_CYCLES   = 1048575,
   parameter int                  REPEAT_CYCLES = 262143
) (
   input  logic            CLK,
   input  logic            RST,
   bcd_field_reg_if.slave  bus,
   output logic [1:0]      dbg_state
);

   localparam int W       = 4 * DIGITS;
   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             held_up;   // direction of the key that armed HOLD/REPEAT
   logic [W-1:0]     data_q;
   logic             cambio_q;
   logic             mod_q;
   logic             lerr_q;

   logic             key_up;
   logic             key_dn;
   logic             key;
   logic             same_dir;
   logic             step_fire;
   logic             load_req;
   logic             load_ok;
   logic             clamp_req;
   logic [W-1:0]     max_bound;
   logic [W-1:0]     step_val;

   // ---------------------------------------------------------------- helpers
   function automatic logic is_bcd(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Digit-wise increment; a 9 rolls to 0 and carries into the next digit.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      logic [3:0]   d;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (d >= 4'd9) begin
               d = 4'd0;
            end else begin
               d = d + 4'd1;
               c = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   // Digit-wise decrement; a 0 borrows and becomes 9.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      logic [3:0]   d;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (b) begin
            if (d == 4'd0) begin
               d = 4'd9;
            end else begin
               d = d - 4'd1;
               b = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   // ------------------------------------------------------------ upper bound
`ifdef DYN_MAX_EN
   assign max_bound = bus.Max_in;
   assign clamp_req = (data_q > bus.Max_in);
`else
   assign max_bound = MAX_VAL;
   assign clamp_req = 1'b0;
`endif

   // ------------------------------------------------------------ decode
   // UP and DOWN together are treated as no key at all.
   assign key_up   = bus.UP & ~bus.DOWN;
   assign key_dn   = bus.DOWN & ~bus.UP;
   assign key      = key_up | key_dn;
   assign same_dir = (key_up == held_up);
   assign cnt_inc  = cnt + CNT_W'(1);

   assign load_req = ~bus.Modificando & bus.Actualizar;
   assign load_ok  = is_bcd(bus.DATA_in) && (bus.DATA_in >= MIN_VAL) &&
                     (bus.DATA_in <= max_bound);

   always_comb begin
      step_fire = 1'b0;
      if (bus.Modificando && key) begin
         case (state)
            S_IDLE:   step_fire = 1'b1;
            S_HOLD:   step_fire = same_dir && (cnt_inc == CNT_W'(HOLD_CYCLES));
            S_REPEAT: step_fire = same_dir && (cnt_inc == CNT_W'(REPEAT_CYCLES));
            default:  step_fire = 1'b0;
         endcase
      end
   end

   // Wrap uses >= / <= so an out-of-range value still steps back into range.
   always_comb begin
      step_val = data_q;
      if (key_up) begin
         step_val = (data_q >= max_bound) ? MIN_VAL : bcd_inc(data_q);
      end else begin
         step_val = (data_q <= MIN_VAL) ? max_bound : bcd_dec(data_q);
      end
   end

   // ------------------------------------------------------------ key FSM
   // A direction change while armed behaves as a release: back to IDLE, and
   // the new key is taken as a fresh press on the following cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         cnt     <= '0;
         held_up <= 1'b0;
      end else if (!bus.Modificando || !key) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state   <= S_HOLD;
               cnt     <= '0;
               held_up <= key_up;
            end
            S_HOLD: begin
               if (!same_dir) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
                  state <= S_REPEAT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_REPEAT: begin
               if (!same_dir) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else if (cnt_inc == CNT_W'(REPEAT_CYCLES)) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------ data path
   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q   <= RESET_VAL;
         cambio_q <= 1'b0;
         mod_q    <= 1'b0;
         lerr_q   <= 1'b0;
      end else begin
         cambio_q <= 1'b0;
         lerr_q   <= 1'b0;
         if (load_req && load_ok) begin
            data_q <= bus.DATA_in;
            mod_q  <= 1'b0;
         end else begin
            if (load_req) lerr_q <= 1'b1;
            if (!load_req && clamp_req) begin
               data_q <= max_bound;
               mod_q  <= 1'b1;
            end else if (step_fire) begin
               // A step beats a simultaneous Clear_mod.
               data_q   <= step_val;
               cambio_q <= 1'b1;
               mod_q    <= 1'b1;
            end else if (bus.Clear_mod) begin
               mod_q <= 1'b0;
            end
         end
      end
   end

   assign bus.DATA_out   = data_q;
   assign bus.Cambio     = cambio_q;
   assign bus.Modificado = mod_q;
   assign bus.Load_err   = lerr_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_bcd_field_reg.sv
// -----------------------------------------------------------------------------
// tb_bcd_field_reg
// Purpose : Directed self-checking bench for bcd_field_reg. A month field
//           (01..12) and a minute field (00..59) are exercised, plus a day
//           field (01..31) with a dynamic bound when DYN_MAX_EN is defined.
//           HOLD_CYCLES = 8, REPEAT_CYCLES = 4 throughout.
// -----------------------------------------------------------------------------
module tb_bcd_field_reg;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   bcd_field_reg_if #(.W(8)) mi ();
   bcd_field_reg_if #(.W(8)) ni ();
   logic [1:0] m_state;
   logic [1:0] n_state;

   bcd_field_reg #(
      .DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h12), .RESET_VAL(8'h01),
      .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) u_month (
      .CLK(CLK), .RST(RST), .bus(mi.slave), .dbg_state(m_state)
   );

   bcd_field_reg #(
      .DIGITS(2), .MIN_VAL(8'h00), .MAX_VAL(8'h59), .RESET_VAL(8'h00),
      .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) u_minute (
      .CLK(CLK), .RST(RST), .bus(ni.slave), .dbg_state(n_state)
   );

`ifdef DYN_MAX_EN
   bcd_field_reg_if #(.W(8)) di ();
   logic [1:0] d_state;

   bcd_field_reg #(
      .DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h31), .RESET_VAL(8'h01),
      .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
   ) u_day (
      .CLK(CLK), .RST(RST), .bus(di.slave), .dbg_state(d_state)
   );
`endif

   // Inputs change 1 time unit after the rising edge; outputs are sampled at
   // the same point, i.e. after the edge that registered them.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      mi.UP = 1'b0; mi.DOWN = 1'b0; mi.Modificando = 1'b0; mi.Actualizar = 1'b0;
      mi.DATA_in = 8'h00; mi.Clear_mod = 1'b0;
      ni.UP = 1'b0; ni.DOWN = 1'b0; ni.Modificando = 1'b0; ni.Actualizar = 1'b0;
      ni.DATA_in = 8'h00; ni.Clear_mod = 1'b0;
`ifdef DYN_MAX_EN
      mi.Max_in = 8'h12;
      ni.Max_in = 8'h59;
      di.UP = 1'b0; di.DOWN = 1'b0; di.Modificando = 1'b0; di.Actualizar = 1'b0;
      di.DATA_in = 8'h00; di.Clear_mod = 1'b0; di.Max_in = 8'h31;
`endif

      // ---------------- reset state
      RST = 1'b1;
      repeat (3) tick();
      chk("rst_month_data", mi.DATA_out, 8'h01);
      chk("rst_minute_data", ni.DATA_out, 8'h00);
      chk("rst_cambio", mi.Cambio, 1'b0);
      chk("rst_modificado", mi.Modificado, 1'b0);
      chk("rst_load_err", mi.Load_err, 1'b0);
      chk("rst_state", m_state, 2'd0);
      RST = 1'b0;
      tick();

      // ---------------- loads: bad nibble, out of range, then good
      mi.Actualizar = 1'b1; mi.DATA_in = 8'h1A;
      tick();
      chk("load_1A_err", mi.Load_err, 1'b1);
      chk("load_1A_data", mi.DATA_out, 8'h01);
      mi.DATA_in = 8'h13;
      tick();
      chk("load_13_err", mi.Load_err, 1'b1);
      chk("load_13_data", mi.DATA_out, 8'h01);
      mi.DATA_in = 8'h07;
      tick();
      chk("load_07_data", mi.DATA_out, 8'h07);
      chk("load_07_mod", mi.Modificado, 1'b0);
      chk("load_07_err", mi.Load_err, 1'b0);
      mi.DATA_in = 8'h09;
      tick();
      chk("load_09_data", mi.DATA_out, 8'h09);
      mi.Actualizar = 1'b0;

      // ---------------- single step 09 -> 10 (digit carry)
      mi.Modificando = 1'b1; mi.UP = 1'b1;
      tick();
      chk("step_09_up_data", mi.DATA_out, 8'h10);
      chk("step_09_up_cambio", mi.Cambio, 1'b1);
      chk("step_09_up_mod", mi.Modificado, 1'b1);
      mi.UP = 1'b0;
      tick();
      chk("step_pulse_end", mi.Cambio, 1'b0);
      chk("step_hold_data", mi.DATA_out, 8'h10);

      // ---------------- month wrap 12 -> 01 -> 12
      mi.Modificando = 1'b0; mi.Actualizar = 1'b1; mi.DATA_in = 8'h12;
      tick();
      chk("load_12_data", mi.DATA_out, 8'h12);
      chk("load_clears_mod", mi.Modificado, 1'b0);
      mi.Actualizar = 1'b0; mi.Modificando = 1'b1; mi.UP = 1'b1;
      tick();
      chk("wrap_12_up", mi.DATA_out, 8'h01);
      mi.UP = 1'b0;
      tick();
      mi.DOWN = 1'b1;
      tick();
      chk("wrap_01_down", mi.DATA_out, 8'h12);
      mi.DOWN = 1'b0;
      tick();

      // ---------------- minute 00 -> 59 on DOWN, then reload 00
      ni.Modificando = 1'b1; ni.DOWN = 1'b1;
      tick();
      chk("wrap_min_00_down", ni.DATA_out, 8'h59);
      ni.DOWN = 1'b0; ni.Modificando = 1'b0; ni.Actualizar = 1'b1; ni.DATA_in = 8'h00;
      tick();
      chk("load_min_00", ni.DATA_out, 8'h00);
      ni.Actualizar = 1'b0; ni.Modificando = 1'b1;
      tick();

      // ---------------- auto-repeat: UP held 30 cycles
      ni.UP = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         chk($sformatf("repeat_cambio_%0d", i), ni.Cambio,
             ((i == 1) || (i >= 9 && ((i - 9) % 4) == 0)) ? 1'b1 : 1'b0);
      end
      chk("repeat_final_data", ni.DATA_out, 8'h07);
      chk("repeat_state", n_state, 2'd2);
      ni.UP = 1'b0;
      tick();
      chk("release_state", n_state, 2'd0);

      // ---------------- UP and DOWN together: no step
      mi.UP = 1'b1; mi.DOWN = 1'b1;
      tick();
      chk("both_cambio", mi.Cambio, 1'b0);
      tick();
      chk("both_data", mi.DATA_out, 8'h12);
      mi.UP = 1'b0; mi.DOWN = 1'b0;
      tick();

      // ---------------- Clear_mod alone, then with a step
      mi.Clear_mod = 1'b1;
      tick();
      chk("clear_mod_alone", mi.Modificado, 1'b0);
      mi.UP = 1'b1;
      tick();
      chk("clear_vs_step_mod", mi.Modificado, 1'b1);
      chk("clear_vs_step_data", mi.DATA_out, 8'h01);
      mi.UP = 1'b0; mi.Clear_mod = 1'b0;
      tick();

      // ---------------- direction switch without release
      mi.UP = 1'b1;
      tick();
      chk("switch_up_data", mi.DATA_out, 8'h02);
      mi.UP = 1'b0; mi.DOWN = 1'b1;
      tick();
      chk("switch_release_cambio", mi.Cambio, 1'b0);
      chk("switch_release_data", mi.DATA_out, 8'h02);
      tick();
      chk("switch_rearm_cambio", mi.Cambio, 1'b1);
      chk("switch_rearm_data", mi.DATA_out, 8'h01);
      mi.DOWN = 1'b0;
      tick();

      // ---------------- keys ignored outside edit mode
      ni.Modificando = 1'b0; ni.UP = 1'b1;
      tick();
      chk("noedit_cambio", ni.Cambio, 1'b0);
      chk("noedit_data", ni.DATA_out, 8'h07);
      ni.UP = 1'b0; ni.Modificando = 1'b1;
      tick();

      // ---------------- reset in REPEAT with UP still held
      ni.UP = 1'b1;
      repeat (10) tick();
      chk("pre_rst_state", n_state, 2'd2);
      chk("pre_rst_data", ni.DATA_out, 8'h09);
      RST = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("rst_hold_cambio_%0d", i), ni.Cambio, 1'b0);
         chk($sformatf("rst_hold_data_%0d", i), ni.DATA_out, 8'h00);
      end
      chk("rst_month_again", mi.DATA_out, 8'h01);
      RST = 1'b0;
      tick();
      chk("post_rst_new_press", ni.Cambio, 1'b1);
      chk("post_rst_data", ni.DATA_out, 8'h01);
      ni.UP = 1'b0;
      tick();

`ifdef DYN_MAX_EN
      // ---------------- dynamic bound: clamp, load check, wrap
      di.Actualizar = 1'b1; di.DATA_in = 8'h31;
      tick();
      chk("day_load_31", di.DATA_out, 8'h31);
      di.Actualizar = 1'b0; di.Max_in = 8'h28;
      tick();
      chk("day_clamp_data", di.DATA_out, 8'h28);
      chk("day_clamp_mod", di.Modificado, 1'b1);
      di.Actualizar = 1'b1; di.DATA_in = 8'h30;
      tick();
      chk("day_load_30_err", di.Load_err, 1'b1);
      chk("day_load_30_data", di.DATA_out, 8'h28);
      di.Actualizar = 1'b0; di.Modificando = 1'b1; di.UP = 1'b1;
      tick();
      chk("day_wrap_28_up", di.DATA_out, 8'h01);
      di.UP = 1'b0;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
